// File: rtl/wb_stage.sv
// wb_stage: writeback stage between MEM and the register-file write port.
// Non-loads retire in one cycle; loads wait for the dmem response, then are formatted.
`default_nettype none

module wb_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            mem_valid_i,
  output logic            mem_ready_o,
  input  logic [4:0]      mem_rd_addr_i,
  input  logic            mem_rd_we_i,
  input  logic            mem_is_load_i,
  input  logic [2:0]      mem_funct3_i,
  input  logic [1:0]      mem_addr_lo_i,
  input  logic [XLEN-1:0] mem_result_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_we_o,
  output logic            retire_o,
  output logic            load_pending_o,
  output logic [4:0]      pending_rd_o
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [4:0]        ld_rd_q, ld_rd_d;
  logic              ld_we_q, ld_we_d;
  logic [2:0]        ld_f3_q, ld_f3_d;
  logic [1:0]        ld_lo_q, ld_lo_d;
  logic [4:0]        rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]   rd_data_q, rd_data_d;
  logic              rd_we_q, rd_we_d;
  logic              retire_q, retire_d;

  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [XLEN-1:0]   w_fmt;

  always_comb begin
    w_byte = 8'h00;
    case (ld_lo_q)
      2'd0:    w_byte = dmem_rdata_i[7:0];
      2'd1:    w_byte = dmem_rdata_i[15:8];
      2'd2:    w_byte = dmem_rdata_i[23:16];
      default: w_byte = dmem_rdata_i[31:24];
    endcase
    // Half lane uses only addr_lo[1]; misaligned halves never reach this stage.
    w_half = ld_lo_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (ld_f3_q)
      3'b000:  w_fmt = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b001:  w_fmt = {{(XLEN-16){w_half[15]}}, w_half};
      3'b100:  w_fmt = {{(XLEN-8){1'b0}}, w_byte};
      3'b101:  w_fmt = {{(XLEN-16){1'b0}}, w_half};
      default: w_fmt = dmem_rdata_i;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ld_rd_d   = ld_rd_q;
    ld_we_d   = ld_we_q;
    ld_f3_d   = ld_f3_q;
    ld_lo_d   = ld_lo_q;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    rd_we_d   = 1'b0;
    retire_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_valid_i) begin
          if (mem_is_load_i) begin
            ld_rd_d = mem_rd_addr_i;
            ld_we_d = mem_rd_we_i;
            ld_f3_d = mem_funct3_i;
            ld_lo_d = mem_addr_lo_i;
            state_d = WAIT_RSP;
          end else begin
            retire_d = 1'b1;
            rd_we_d  = mem_rd_we_i & (mem_rd_addr_i != 5'd0);
            // Address/data only move on a real write so they hold otherwise.
            if (rd_we_d) begin
              rd_addr_d = mem_rd_addr_i;
              rd_data_d = mem_result_i;
            end
          end
        end
      end
      WAIT_RSP: begin
        if (dmem_rvalid_i) begin
          retire_d = 1'b1;
          rd_we_d  = ld_we_q & (ld_rd_q != 5'd0);
          if (rd_we_d) begin
            rd_addr_d = ld_rd_q;
            rd_data_d = w_fmt;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      ld_rd_q   <= 5'd0;
      ld_we_q   <= 1'b0;
      ld_f3_q   <= 3'd0;
      ld_lo_q   <= 2'd0;
      rd_addr_q <= 5'd0;
      rd_data_q <= '0;
      rd_we_q   <= 1'b0;
      retire_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_rd_q   <= ld_rd_d;
      ld_we_q   <= ld_we_d;
      ld_f3_q   <= ld_f3_d;
      ld_lo_q   <= ld_lo_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      rd_we_q   <= rd_we_d;
      retire_q  <= retire_d;
    end
  end

  assign mem_ready_o    = (state_q == IDLE);
  assign load_pending_o = (state_q == WAIT_RSP);
  assign pending_rd_o   = (state_q == WAIT_RSP) ? ld_rd_q : 5'd0;
  assign rd_addr_o      = rd_addr_q;
  assign rd_data_o      = rd_data_q;
  assign rd_we_o        = rd_we_q;
  assign retire_o       = retire_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed vector table plus a reset-during-load sequence for wb_stage.
`default_nettype none

module tb_wb_stage;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        mem_valid_i;
  logic        mem_ready_o;
  logic [4:0]  mem_rd_addr_i;
  logic        mem_rd_we_i;
  logic        mem_is_load_i;
  logic [2:0]  mem_funct3_i;
  logic [1:0]  mem_addr_lo_i;
  logic [31:0] mem_result_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        rd_we_o;
  logic        retire_o;
  logic        load_pending_o;
  logic [4:0]  pending_rd_o;

  int total = 0;
  int bad   = 0;

  wb_stage #(.XLEN(32)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .mem_valid_i    (mem_valid_i),
    .mem_ready_o    (mem_ready_o),
    .mem_rd_addr_i  (mem_rd_addr_i),
    .mem_rd_we_i    (mem_rd_we_i),
    .mem_is_load_i  (mem_is_load_i),
    .mem_funct3_i   (mem_funct3_i),
    .mem_addr_lo_i  (mem_addr_lo_i),
    .mem_result_i   (mem_result_i),
    .dmem_rvalid_i  (dmem_rvalid_i),
    .dmem_rdata_i   (dmem_rdata_i),
    .rd_addr_o      (rd_addr_o),
    .rd_data_o      (rd_data_o),
    .rd_we_o        (rd_we_o),
    .retire_o       (retire_o),
    .load_pending_o (load_pending_o),
    .pending_rd_o   (pending_rd_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic        we;
    logic        ld;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] res;
    logic        rv;
    logic [31:0] rdata;
    logic        e_rdy;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_ret;
    logic        e_pend;
    logic [4:0]  e_prd;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];

  function automatic vec_t mkv(
    input logic v, input logic [4:0] rd, input logic we, input logic ld,
    input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] res,
    input logic rv, input logic [31:0] rdata,
    input logic e_rdy, input logic e_we, input logic [4:0] e_addr,
    input logic [31:0] e_data, input logic e_ret, input logic e_pend,
    input logic [4:0] e_prd);
    vec_t t;
    t.v = v; t.rd = rd; t.we = we; t.ld = ld; t.f3 = f3; t.lo = lo;
    t.res = res; t.rv = rv; t.rdata = rdata; t.e_rdy = e_rdy;
    t.e_we = e_we; t.e_addr = e_addr; t.e_data = e_data; t.e_ret = e_ret;
    t.e_pend = e_pend; t.e_prd = e_prd;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    mem_valid_i   = t.v;
    mem_rd_addr_i = t.rd;
    mem_rd_we_i   = t.we;
    mem_is_load_i = t.ld;
    mem_funct3_i  = t.f3;
    mem_addr_lo_i = t.lo;
    mem_result_i  = t.res;
    dmem_rvalid_i = t.rv;
    dmem_rdata_i  = t.rdata;
  endtask

  task automatic idle_inputs();
    mem_valid_i = 0; mem_rd_addr_i = 0; mem_rd_we_i = 0; mem_is_load_i = 0;
    mem_funct3_i = 0; mem_addr_lo_i = 0; mem_result_i = 0;
    dmem_rvalid_i = 0; dmem_rdata_i = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".we"},    {31'd0, rd_we_o}, 32'd0);
    chk({tag, ".ret"},   {31'd0, retire_o}, 32'd0);
    chk({tag, ".addr"},  {27'd0, rd_addr_o}, 32'd0);
    chk({tag, ".data"},  rd_data_o, 32'd0);
    chk({tag, ".pend"},  {31'd0, load_pending_o}, 32'd0);
    chk({tag, ".prd"},   {27'd0, pending_rd_o}, 32'd0);
  endtask

  initial begin
    //            v  rd  we ld f3      lo     res           rv rdata         rdy we addr data          ret pnd prd
    vecs[0]  = mkv(1, 5,  1, 0, 3'b000, 2'd0, 32'h12345678, 0, 32'h0,        1, 1, 5,  32'h12345678, 1, 0, 0);
    vecs[1]  = mkv(0, 0,  0, 0, 3'b000, 2'd0, 32'h0,        0, 32'h0,        1, 0, 5,  32'h12345678, 0, 0, 0);
    vecs[2]  = mkv(1, 1,  1, 0, 3'b000, 2'd0, 32'h11,       0, 32'h0,        1, 1, 1,  32'h11,       1, 0, 0);
    vecs[3]  = mkv(1, 2,  1, 0, 3'b000, 2'd0, 32'h22,       0, 32'h0,        1, 1, 2,  32'h22,       1, 0, 0);
    vecs[4]  = mkv(1, 3,  1, 0, 3'b000, 2'd0, 32'h33,       0, 32'h0,        1, 1, 3,  32'h33,       1, 0, 0);
    // LB rd=7 lane 2, three wait cycles then the response
    vecs[5]  = mkv(1, 7,  1, 1, 3'b000, 2'd2, 32'h0,        0, 32'h0,        1, 0, 3,  32'h33,       0, 1, 7);
    vecs[6]  = mkv(0, 0,  0, 0, 3'b000, 2'd0, 32'h0,        0, 32'h0,        0, 0, 3,  32'h33,       0, 1, 7);
    vecs[7]  = mkv(0, 0,  0, 0, 3'b000, 2'd0, 32'h0,        0, 32'h0,        0, 0, 3,  32'h33,       0, 1, 7);
    vecs[8]  = mkv(0, 0,  0, 0, 3'b000, 2'd0, 32'h0,        0, 32'h0,        0, 0, 3,  32'h33,       0, 1, 7);
    vecs[9]  = mkv(0, 0,  0, 0, 3'b000, 2'd0, 32'h0,        1, 32'h00800000, 0, 1, 7,  32'hFFFFFF80, 1, 0, 0);
    vecs[10] = mkv(1, 8,  1, 1, 3'b101, 2'd2, 32'h0,        0, 32'h0,        1, 0, 7,  32'hFFFFFF80, 0, 1, 8);
    vecs[11] = mkv(0, 0,  0, 0, 3'b000, 2'd0, 32'h0,        1, 32'h80010000, 0, 1, 8,  32'h00008001, 1, 0, 0);
    vecs[12] = mkv(1, 9,  1, 1, 3'b001, 2'd2, 32'h0,        0, 32'h0,        1, 0, 8,  32'h00008001, 0, 1, 9);
    vecs[13] = mkv(0, 0,  0, 0, 3'b000, 2'd0, 32'h0,        1, 32'h80010000, 0, 1, 9,  32'hFFFF8001, 1, 0, 0);
    vecs[14] = mkv(1, 10, 1, 1, 3'b010, 2'd0, 32'h0,        0, 32'h0,        1, 0, 9,  32'hFFFF8001, 0, 1, 10);
    vecs[15] = mkv(0, 0,  0, 0, 3'b000, 2'd0, 32'h0,        1, 32'hDEADBEEF, 0, 1, 10, 32'hDEADBEEF, 1, 0, 0);
    // stray response while idle
    vecs[16] = mkv(0, 0,  0, 0, 3'b000, 2'd0, 32'h0,        1, 32'h00012345, 1, 0, 10, 32'hDEADBEEF, 0, 0, 0);
    // x0 destinations: retire without write
    vecs[17] = mkv(1, 0,  1, 0, 3'b000, 2'd0, 32'h0000AAAA, 0, 32'h0,        1, 0, 10, 32'hDEADBEEF, 1, 0, 0);
    vecs[18] = mkv(1, 0,  1, 1, 3'b010, 2'd0, 32'h0,        0, 32'h0,        1, 0, 10, 32'hDEADBEEF, 0, 1, 0);
    vecs[19] = mkv(0, 0,  0, 0, 3'b000, 2'd0, 32'h0,        1, 32'h00000055, 0, 0, 10, 32'hDEADBEEF, 1, 0, 0);
    vecs[20] = mkv(1, 11, 1, 1, 3'b100, 2'd3, 32'h0,        0, 32'h0,        1, 0, 10, 32'hDEADBEEF, 0, 1, 11);
    vecs[21] = mkv(0, 0,  0, 0, 3'b000, 2'd0, 32'h0,        1, 32'hF0000000, 0, 1, 11, 32'h000000F0, 1, 0, 0);
    vecs[22] = mkv(1, 12, 0, 0, 3'b000, 2'd0, 32'h00000007, 0, 32'h0,        1, 0, 11, 32'h000000F0, 1, 0, 0);

    rst_n_i = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    chk_all_zero("reset");
    chk("reset.ready", {31'd0, mem_ready_o}, 32'd1);

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i]);
      chk($sformatf("v%0d.ready", i), {31'd0, mem_ready_o}, {31'd0, vecs[i].e_rdy});
      @(posedge clk_i);
      #1;
      chk($sformatf("v%0d.we", i),   {31'd0, rd_we_o},        {31'd0, vecs[i].e_we});
      chk($sformatf("v%0d.addr", i), {27'd0, rd_addr_o},      {27'd0, vecs[i].e_addr});
      chk($sformatf("v%0d.data", i), rd_data_o,               vecs[i].e_data);
      chk($sformatf("v%0d.ret", i),  {31'd0, retire_o},       {31'd0, vecs[i].e_ret});
      chk($sformatf("v%0d.pend", i), {31'd0, load_pending_o}, {31'd0, vecs[i].e_pend});
      chk($sformatf("v%0d.prd", i),  {27'd0, pending_rd_o},   {27'd0, vecs[i].e_prd});
    end

    // Reset while a load is pending: the load is dropped and a late response ignored.
    idle_inputs();
    mem_valid_i = 1; mem_is_load_i = 1; mem_rd_addr_i = 5'd13; mem_rd_we_i = 1;
    mem_funct3_i = 3'b010;
    @(posedge clk_i);
    #1;
    idle_inputs();
    chk("rstld.pend", {31'd0, load_pending_o}, 32'd1);
    chk("rstld.prd",  {27'd0, pending_rd_o}, 32'd13);
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b0;
    #1;
    chk_all_zero("rstld.async");
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    chk("rstld.ready", {31'd0, mem_ready_o}, 32'd1);
    dmem_rvalid_i = 1; dmem_rdata_i = 32'hCAFEF00D;
    @(posedge clk_i);
    #1;
    dmem_rvalid_i = 0;
    chk_all_zero("rstld.late");
    chk("rstld.ready2", {31'd0, mem_ready_o}, 32'd1);
    @(posedge clk_i);
    #1;
    chk("rstld.we2",  {31'd0, rd_we_o}, 32'd0);
    chk("rstld.ret2", {31'd0, retire_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
